regfile_write_decode: RTL

REGFILE_WRITE_DECODE -- requirements
Module: regfile_write_decode

---
 rtl/regfile_write_decode_pkg.sv | 17 +
 rtl/regfile_write_decode_dec.sv | 19 +
 rtl/regfile_write_decode.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_write_decode_pkg.sv
// Shared constants, FSM state type and zero-register index for the register file.
package regfile_write_decode_pkg;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 32;
    localparam int ADDR_BITS = 5;

    localparam logic [ADDR_BITS-1:0] ZERO_REG = '0;
    localparam logic [ADDR_BITS-1:0] LAST_REG = 5'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] FIRST_CLR_REG = 5'd1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/regfile_write_decode_dec.sv
// 5-to-32 one-hot decoder with enable; shared by the write and clear paths.
// Purely combinational, zero latency; no backpressure.
// All outputs are low when en_i is low.
module decoder1to32
    import regfile_write_decode_pkg::*;
(
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic                 en_i,
    output logic [31:0]          onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_decode.sv
// Two-read/one-write register file with constant-zero r0 and a sequential clear.
// Reads are combinational (0 cycles); writes commit on the next rising edge.
// While busy clearing, writes are dropped silently and clr_req is ignored.
module regfile_write_decode
    import regfile_write_decode_pkg::*;
#(
    parameter int WIDTH  = regfile_write_decode_pkg::WIDTH,
    parameter int DEPTH  = regfile_write_decode_pkg::DEPTH,
    parameter bit BYPASS = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wr_enable,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 clr_req,
    input  logic [ADDR_BITS-1:0] rd_addr1,
    input  logic [ADDR_BITS-1:0] rd_addr2,
    output logic [WIDTH-1:0]     rd_data1,
    output logic [WIDTH-1:0]     rd_data2,
    output logic                 busy
);

    clr_state_t           state_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic                 busy_q;

    logic [WIDTH-1:0]     mem_q [DEPTH];

    logic                 wr_commit;
    logic [ADDR_BITS-1:0] dec_addr;
    logic                 dec_en;
    logic [WIDTH-1:0]     row_dat;
    logic [31:0]          row_en;

    // Writes to r0 never reach the decoder, so r0 stays zero without a special case.
    assign wr_commit = wr_enable && !busy_q && !clr_req && (wr_addr != ZERO_REG);

    assign dec_addr = busy_q ? idx_q : wr_addr;
    assign dec_en   = busy_q | wr_commit;
    assign row_dat  = busy_q ? '0 : wr_data;

    decoder1to32 u_dec (
        .addr_i   (dec_addr),
        .en_i     (dec_en),
        .onehot_o (row_en)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= FIRST_CLR_REG;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        idx_q   <= FIRST_CLR_REG;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx_q == LAST_REG) begin
                        state_q <= IDLE;
                        idx_q   <= FIRST_CLR_REG;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (row_en[i]) begin
                    mem_q[i] <= row_dat;
                end
            end
        end
    end

    assign rd_data1 = (rd_addr1 == ZERO_REG) ? '0 :
                      (BYPASS && wr_commit && (rd_addr1 == wr_addr)) ? wr_data :
                      mem_q[rd_addr1];

    assign rd_data2 = (rd_addr2 == ZERO_REG) ? '0 :
                      (BYPASS && wr_commit && (rd_addr2 == wr_addr)) ? wr_data :
                      mem_q[rd_addr2];

    assign busy = busy_q;

endmodule
